mem_lsu: RTL
============

# mem_lsu

Memory-stage load/store unit of the RISC-V pipeline. It consumes the execute stage's memory-side outputs: operation code, effective address and store data. It drives a single-port, word-wide data bus with a request/acknowledge handshake and returns the aligned, sign- or zero-extended load result toward write-back. While a bus access is outstanding it raises a stall request, and the pipeline holds its inputs stable until the stall is released.

## Interface
- No parameters. Widths are fixed: data/address 32, register address 5, aluop 8.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (rst==0 resets)
- aluop_i  in  8  operation code from execute; memory ops are EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP from the shared defines header
- mem_addr_i  in  32  effective address (rs1 + offset)
- reg2_i  in  32  store data (rs2)
- wd_i / wreg_i / wdata_i  in  5/1/32  destination, write-enable and ALU result from execute
- wd_o / wreg_o / wdata_o  out  5/1/32  write-back destination, enable and data
- stallreq_o  out  1  hold the IF, ID, EX and MEM pipeline registers
- misalign_o  out  1  one-cycle pulse on a misaligned access
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word address {mem_addr_i[31:2],2'b00}
- bus_sel_o  out  4  byte-lane enables, little-endian (lane 0 = bits 7:0)
- bus_wdata_o  out  32  store data, replicated across lanes
- bus_ack_i  in  1  access complete; rdata is valid in the same cycle
- bus_rdata_i  in  32  read word

## Operation
- States are IDLE, BUSY and DONE. Reset puts the FSM in IDLE.
- Reset values of outputs: wreg_o=0, wd_o=0, wdata_o=0, stallreq_o=0, misalign_o=0, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0, bus_wdata_o=0. The data register is cleared to 0.
- Non-memory op in IDLE: pass-through, with wd_o=wd_i, wreg_o=wreg_i and wdata_o=wdata_i. No stall and no bus activity.
- Memory op in IDLE:
  - If aligned: assert bus_req_o combinationally and stallreq_o=1, then go to BUSY on the next edge.
  - If bus_ack_i is already high at that edge, go directly to DONE.
- BUSY: hold bus_req_o, bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o, and keep stallreq_o=1. On the edge where bus_ack_i=1, capture bus_rdata_i and go to DONE.
- DONE: stallreq_o=0 and bus_req_o=0. Loads drive wreg_o=wreg_i and wdata_o=extended data; stores drive wreg_o=0. Next state is always IDLE. DONE never re-issues, because the inputs still hold the same instruction.
- Lane select uses a = mem_addr_i[1:0]:
  - Byte: sel = 1<<a; data = rdata[8a+7:8a].
  - Half: sel = 0011 when a=0, 1100 when a=2; data = rdata[16·a[1]+15 : 16·a[1]].
  - Word: sel = 1111.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Store data: SB = {4{reg2_i[7:0]}}, SH = {2{reg2_i[15:0]}}, SW = reg2_i.
- Misaligned access (H with a[0]=1, W with a≠0):
  - No request and no stall; misalign_o=1 for that cycle; wreg_o=0.
  - The FSM stays in IDLE.
- An unknown aluop is treated as a non-memory op.
- Asserting rst mid-access immediately forces IDLE and drops bus_req_o. The pending ack is ignored.

## Timing
- Non-memory op: 0 added cycles; the path is combinational.
- Memory op: 1 issue cycle, plus N wait cycles where N is the number of cycles without ack, plus 1 DONE cycle. Minimum is 2 cycles, with stallreq_o high for N+1 of them.
- The bus request is held steady until ack; bus outputs do not change while bus_req_o=1.
- bus_ack_i is ignored when bus_req_o=0.
- The DONE result is combinational from the captured register, and the pipeline latches it on the following edge.

## Test plan
- Load word with zero-wait ack:
  - Stimulus: LW at 0x100, ack on the first edge, rdata=0xDEADBEEF.
  - Response: bus_sel 1111, stall high for 1 cycle, then wdata_o=0xDEADBEEF with wreg_o=1.
- Signed versus unsigned byte:
  - Stimulus: LB then LBU at 0x103, rdata=0x80xxxxxx.
  - Response: LB returns 0xFFFFFF80 and LBU returns 0x00000080, both with sel 1000.
- Halfword store with 3 wait cycles:
  - Stimulus: SH at 0x202, reg2=0x1234ABCD.
  - Response: bus_addr 0x200, sel 1100, wdata 0xABCDABCD held stable; stall for 4 cycles; wreg_o=0 in DONE.
- Misaligned load:
  - Stimulus: LW at 0x101.
  - Response: no bus_req, misalign_o pulses once, stallreq_o=0, wreg_o=0.
- Back-to-back accesses:
  - Stimulus: LW then SW.
  - Response: the second request starts in the cycle after DONE, with no duplicate request for the first instruction.
- Reset mid-access:
  - Stimulus: rst=0 during BUSY.
  - Response: bus_req_o and stallreq_o drop to 0 immediately; a later ack has no effect.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit. Issues one word-wide bus access per
// memory instruction through an IDLE/BUSY/DONE handshake, stalls the pipeline
// while the access is outstanding, and returns aligned, extended load data.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  // Memory operation codes shared with the execute stage
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // Access size encoding
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;

  logic        is_load, is_store, is_uns, mem_op, misal, issue;
  logic [1:0]  size;
  logic [1:0]  a;

  assign a = mem_addr_i[1:0];

  // Byte-lane enables for a given size and byte offset
  function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      SZ_B:    s = 4'b0001 << off;
      SZ_H:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated across all lanes so any lane select picks it up
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Select the addressed byte/half from the read word and extend it
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Decode the operation code into direction, size and signedness
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_uns   = 1'b0;
    size     = SZ_W;
    case (aluop_i)
      EXE_LB_OP:  begin is_load = 1'b1; size = SZ_B; end
      EXE_LH_OP:  begin is_load = 1'b1; size = SZ_H; end
      EXE_LW_OP:  begin is_load = 1'b1; size = SZ_W; end
      EXE_LBU_OP: begin is_load = 1'b1; size = SZ_B; is_uns = 1'b1; end
      EXE_LHU_OP: begin is_load = 1'b1; size = SZ_H; is_uns = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; size = SZ_B; end
      EXE_SH_OP:  begin is_store = 1'b1; size = SZ_H; end
      EXE_SW_OP:  begin is_store = 1'b1; size = SZ_W; end
      default:    ;
    endcase
  end

  assign mem_op = is_load | is_store;
  assign misal  = ((size == SZ_H) && a[0]) || ((size == SZ_W) && (a != 2'b00));

  // Next-state logic; ack is only honoured while a request is on the bus
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (mem_op && !misal) begin
          if (bus_ack_i) begin
            state_d = DONE;
            data_d  = bus_rdata_i;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          state_d = DONE;
          data_d  = bus_rdata_i;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured read word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Request is live while issuing from IDLE or waiting in BUSY; reset kills it at once
  assign issue = rst && (((state_q == IDLE) && mem_op && !misal) || (state_q == BUSY));

  // Bus and pipeline-side outputs; inputs are held stable while stalled
  always_comb begin
    bus_req_o   = issue;
    bus_we_o    = issue && is_store;
    bus_addr_o  = issue ? {mem_addr_i[31:2], 2'b00} : 32'h0;
    bus_sel_o   = issue ? lane_sel(size, a) : 4'h0;
    bus_wdata_o = issue ? store_data(size, reg2_i) : 32'h0;
    stallreq_o  = issue;
    misalign_o  = rst && (state_q == IDLE) && mem_op && misal;
    wd_o        = rst ? wd_i : 5'h0;
    wreg_o      = 1'b0;
    wdata_o     = 32'h0;
    if (rst) begin
      wdata_o = wdata_i;
      if (state_q == DONE) begin
        wreg_o = is_load ? wreg_i : 1'b0;
        if (is_load) wdata_o = load_ext(data_q, size, a, is_uns);
      end else if (!mem_op) begin
        wreg_o = wreg_i;
      end
    end
  end

endmodule
